mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 19 +
 rtl/arb_starve_cnt.sv | 41 ++++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Holds the default bus widths and the arbiter state encoding.
package riscv_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

    function automatic logic arb_is_busy(input arb_state_e st);
        return (st == ARB_BUSY_IF) || (st == ARB_BUSY_DM);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants issued while a fetch is left waiting.
// Clear takes precedence over increment.
module arb_starve_cnt #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and data (DM) ports.
// Grants are combinational in IDLE; the winner's payload is latched and replayed on mem_*.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic              drop_q, drop_d;
    logic              starve_sat_s;

    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .inc_i (dm_gnt & if_req),
        .clr_i (if_gnt | ~if_req),
        .sat_o (starve_sat_s)
    );

    // state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_gnt) begin
                    state_d = ARB_BUSY_IF;
                end else if (dm_gnt) begin
                    state_d = ARB_BUSY_DM;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_DM: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // grants and memory request; a starved fetch overrides data priority
    always_comb begin
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        mem_req = arb_is_busy(state_q);
        if ((state_q == ARB_IDLE) && !sys_rst) begin
            if (if_req && (!dm_req || starve_sat_s)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else begin
                if_gnt = 1'b0;
                dm_gnt = 1'b0;
            end
        end else begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end
    end

    // payload latch, read-data capture, completion strobes and flush tracking
    always_comb begin
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        drop_d      = drop_q;
        case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (if_gnt) begin
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    be_d    = {BE_W{1'b1}};
                    wdata_d = {DATA_W{1'b0}};
                    drop_d  = if_flush;
                end else if (dm_gnt) begin
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    be_d    = dm_be;
                    wdata_d = dm_wdata;
                end else begin
                    addr_d  = addr_q;
                end
            end
            ARB_BUSY_IF: begin
                // a flush on the acking cycle still suppresses the response
                if (mem_ack) begin
                    drop_d = 1'b0;
                    if (!(drop_q || if_flush)) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        if_rvalid_d = 1'b0;
                    end
                end else begin
                    drop_d = drop_q | if_flush;
                end
            end
            ARB_BUSY_DM: begin
                if (mem_ack) begin
                    dm_rvalid_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    dm_rvalid_d = 1'b0;
                end
            end
            default: drop_d = 1'b0;
        endcase
    end

    // datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_q      <= {ADDR_W{1'b0}};
            we_q        <= 1'b0;
            be_q        <= {BE_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after the falling edge,
// outputs are checked 1 time unit later with immediate assertions.
module tb_mem_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    mem_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // reset: no grants even with a request pending
        step(); #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_dm_gnt", dm_gnt, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_dm_rvalid", dm_rvalid, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_state", dut.state_q, 2'd0);
        sys_rst = 1'b0; if_req = 1'b0;
        step();

        // plain fetch: gnt cycle 0, ack on 2nd req cycle, rvalid cycle 3
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("f_if_gnt", if_gnt, 1'b1);
        chk("f_dm_gnt", dm_gnt, 1'b0);
        step(); if_req = 1'b0; #1;
        chk("f_mem_req1", mem_req, 1'b1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", mem_we, 1'b0);
        chk("f_busy_gnt", if_gnt, 1'b0);
        step(); mem_ack = 1'b1; mem_rdata = 32'h13; #1;
        chk("f_mem_req2", mem_req, 1'b1);
        chk("f_rvalid_early", if_rvalid, 1'b0);
        step(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        chk("f_if_rvalid", if_rvalid, 1'b1);
        chk("f_if_rdata", if_rdata, 32'h13);
        chk("f_mem_req_off", mem_req, 1'b0);
        step(); #1;
        chk("f_rvalid_pulse", if_rvalid, 1'b0);
        chk("f_rdata_hold", if_rdata, 32'h13);

        // simultaneous requests: data first, fetch granted in dm_rvalid cycle
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000; #1;
        chk("c_dm_gnt", dm_gnt, 1'b1);
        chk("c_if_gnt", if_gnt, 1'b0);
        step(); dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE0001; #1;
        chk("c_mem_addr", mem_addr, 32'h2000);
        chk("c_busy_if_gnt", if_gnt, 1'b0);
        step(); mem_ack = 1'b0; #1;
        chk("c_dm_rvalid", dm_rvalid, 1'b1);
        chk("c_dm_rdata", dm_rdata, 32'hCAFE0001);
        chk("c_if_gnt2", if_gnt, 1'b1);
        chk("c_if_rvalid", if_rvalid, 1'b0);
        step(); if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55; #1;
        chk("c_mem_addr2", mem_addr, 32'h200);
        chk("c_dm_rvalid_off", dm_rvalid, 1'b0);
        step(); mem_ack = 1'b0; #1;
        chk("c_if_rvalid2", if_rvalid, 1'b1);
        chk("c_if_rdata", if_rdata, 32'h55);

        // starvation: four data grants, then the waiting fetch wins
        if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b1; dm_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dm_addr = 32'h3000 + 32'(k * 4); #1;
            chk("s_dm_gnt", dm_gnt, 1'b1);
            chk("s_if_gnt", if_gnt, 1'b0);
            step(); mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(k); #1;
            chk("s_mem_addr", mem_addr, 32'h3000 + 32'(k * 4));
            step(); mem_ack = 1'b0; #1;
            chk("s_dm_rvalid", dm_rvalid, 1'b1);
            chk("s_dm_rdata", dm_rdata, 32'h1000 + 32'(k));
        end
        chk("s_cnt_sat", dut.u_starve.cnt_q, 3'd4);
        chk("s_if_win", if_gnt, 1'b1);
        chk("s_dm_lose", dm_gnt, 1'b0);
        step(); if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77; #1;
        chk("s_cnt_clr", dut.u_starve.cnt_q, 3'd0);
        chk("s_mem_addr_if", mem_addr, 32'h400);
        step(); mem_ack = 1'b0; #1;
        chk("s_if_rvalid", if_rvalid, 1'b1);
        chk("s_if_rdata", if_rdata, 32'h77);
        chk("s_dm_rvalid_off", dm_rvalid, 1'b0);

        // partial write: strobe only, read data untouched
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; #1;
        chk("w_dm_gnt", dm_gnt, 1'b1);
        step(); dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
        chk("w_mem_req", mem_req, 1'b1);
        chk("w_mem_we", mem_we, 1'b1);
        chk("w_mem_be", mem_be, 4'b0011);
        chk("w_mem_addr", mem_addr, 32'h40);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step(); mem_ack = 1'b0; #1;
        chk("w_dm_rvalid", dm_rvalid, 1'b1);
        chk("w_dm_rdata", dm_rdata, 32'h1003);

        // ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step(); mem_ack = 1'b0; #1;
        chk("i_if_rvalid", if_rvalid, 1'b0);
        chk("i_dm_rvalid", dm_rvalid, 1'b0);
        chk("i_mem_req", mem_req, 1'b0);

        // flush while busy: memory completes, response dropped
        if_req = 1'b1; if_addr = 32'h300; #1;
        chk("fl_gnt", if_gnt, 1'b1);
        step(); if_req = 1'b0; if_flush = 1'b1; #1;
        chk("fl_mem_req1", mem_req, 1'b1);
        step(); if_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h88; #1;
        chk("fl_mem_req2", mem_req, 1'b1);
        step(); mem_ack = 1'b0; #1;
        chk("fl_no_rvalid", if_rvalid, 1'b0);
        chk("fl_mem_req_off", mem_req, 1'b0);

        // flush in the grant cycle also drops the response
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h308; #1;
        chk("fg_gnt", if_gnt, 1'b1);
        step(); if_req = 1'b0; if_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h89; #1;
        step(); mem_ack = 1'b0; #1;
        chk("fg_no_rvalid", if_rvalid, 1'b0);

        // next fetch after the flushes is served normally
        if_req = 1'b1; if_addr = 32'h304; #1;
        chk("fn_gnt", if_gnt, 1'b1);
        step(); if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99; #1;
        chk("fn_mem_addr", mem_addr, 32'h304);
        step(); mem_ack = 1'b0; #1;
        chk("fn_rvalid", if_rvalid, 1'b1);
        chk("fn_rdata", if_rdata, 32'h99);

        // reset mid data access abandons it
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h80; #1;
        chk("r_dm_gnt", dm_gnt, 1'b1);
        step(); dm_req = 1'b0; #1;
        chk("r_mem_req", mem_req, 1'b1);
        sys_rst = 1'b1; #1;
        chk("r_gnt_in_rst", dm_gnt, 1'b0);
        step(); sys_rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFEEDF00D; #1;
        chk("r_mem_req_off", mem_req, 1'b0);
        chk("r_state", dut.state_q, 2'd0);
        chk("r_dm_rvalid", dm_rvalid, 1'b0);
        step(); mem_ack = 1'b0; #1;
        chk("r_dm_rvalid2", dm_rvalid, 1'b0);
        chk("r_dm_rdata", dm_rdata, 32'h0);
        chk("r_if_rdata", if_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
